// File: rtl/nanosoc_busmatrix_pkg.sv
// Shared AHB-Lite encodings and types for the nanosoc bus matrix.
// The input-stage FSM state is the concatenation {pend, dphase}.
package nanosoc_busmatrix_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef struct packed {
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       mastlock;
  } ahb_ctrl_t;

  typedef enum logic [1:0] {
    ST_PASS      = 2'b00,
    ST_DATA      = 2'b01,
    ST_HOLD      = 2'b10,
    ST_HOLD_DATA = 2'b11
  } hold_state_e;

  // Only NONSEQ and SEQ carry a transfer; IDLE and BUSY never request.
  function automatic logic isValidTrans(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/nanosoc_busmatrix_hold_reg.sv
// Address/control hold bank: captures a stalled address phase and muxes
// either the live master fields or the held copy onto the output-stage bus.
module nanosoc_busmatrix_hold_reg
  import nanosoc_busmatrix_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  capture_i,
  input  logic                  hold_i,
  input  logic                  sel_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  ahb_ctrl_t             ctrl_i,
  output logic                  sel_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output ahb_ctrl_t             ctrl_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  ahb_ctrl_t             ctrl_q, ctrl_d;

  always_comb begin
    addr_d = addr_q;
    ctrl_d = ctrl_q;
    if (capture_i) begin
      addr_d = addr_i;
      ctrl_d = ctrl_i;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= '0;
      ctrl_q <= '0;
    end else begin
      addr_q <= addr_d;
      ctrl_q <= ctrl_d;
    end
  end

  // A deselected master must never look like it is requesting a transfer.
  always_comb begin
    sel_o  = sel_i;
    addr_o = addr_i;
    ctrl_o = ctrl_i;
    if (!sel_i) ctrl_o.trans = HTRANS_IDLE;
    if (hold_i) begin
      sel_o  = 1'b1;
      addr_o = addr_q;
      ctrl_o = ctrl_q;
    end
  end

endmodule

// File: rtl/nanosoc_busmatrix_input_hold.sv
// Master-side input stage of the bus matrix: holds address phases the output
// stage could not take and returns the data-phase ready/response to the master.
module nanosoc_busmatrix_input_hold
  import nanosoc_busmatrix_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic                  sel_op,
  output logic [ADDR_WIDTH-1:0] addr_op,
  output logic [1:0]            trans_op,
  output logic                  write_op,
  output logic [2:0]            size_op,
  output logic [2:0]            burst_op,
  output logic [3:0]            prot_op,
  output logic                  mastlock_op,
  output logic                  trans_pending,
  input  logic                  addr_accept,
  input  logic                  data_readyout,
  input  logic                  data_resp
);

  hold_state_e state_q, state_d;
  logic        pend, dphase;
  logic        newTran, capture, issued;
  logic        pendNext, dphaseNext;
  ahb_ctrl_t   ctrlIn, ctrlOut;

  assign pend   = (state_q == ST_HOLD) || (state_q == ST_HOLD_DATA);
  assign dphase = (state_q == ST_DATA) || (state_q == ST_HOLD_DATA);

  assign ctrlIn = '{trans: HTRANSS, write: HWRITES, size: HSIZES,
                    burst: HBURSTS, prot: HPROTS, mastlock: HMASTLOCKS};

  nanosoc_busmatrix_hold_reg #(.ADDR_WIDTH(ADDR_WIDTH)) u_hold_reg (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .capture_i (capture),
    .hold_i    (pend),
    .sel_i     (HSELS),
    .addr_i    (HADDRS),
    .ctrl_i    (ctrlIn),
    .sel_o     (sel_op),
    .addr_o    (addr_op),
    .ctrl_o    (ctrlOut)
  );

  assign trans_op    = ctrlOut.trans;
  assign write_op    = ctrlOut.write;
  assign size_op     = ctrlOut.size;
  assign burst_op    = ctrlOut.burst;
  assign prot_op     = ctrlOut.prot;
  assign mastlock_op = ctrlOut.mastlock;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_PASS;
    else          state_q <= state_d;
  end

  // Capture is gated by !pend so a stray request can never clobber the hold.
  always_comb begin
    newTran       = HSELS & isValidTrans(HTRANSS) & HREADYS;
    capture       = newTran & ~addr_accept & ~pend;
    issued        = (newTran | pend) & addr_accept;
    pendNext      = pend ? ~addr_accept : capture;
    dphaseNext    = dphase;
    if (issued)             dphaseNext = 1'b1;
    else if (data_readyout) dphaseNext = 1'b0;
    state_d       = hold_state_e'({pendNext, dphaseNext});

    trans_pending = pend | (HSELS & isValidTrans(HTRANSS));
    HREADYOUTS    = 1'b1;
    HRESPS        = RESP_OKAY;
    if (pend) begin
      HREADYOUTS = 1'b0;
    end else if (dphase) begin
      HREADYOUTS = data_readyout;
      HRESPS     = data_resp;
    end
  end

endmodule

// File: tb/tb_nanosoc_busmatrix_input_hold.sv
// Scoreboard bench: stimulus pushes the reference model's expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_nanosoc_busmatrix_input_hold;
  import nanosoc_busmatrix_pkg::*;

  localparam int AW = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          HSELS = 1'b0;
  logic [AW-1:0] HADDRS = '0;
  logic [1:0]    HTRANSS = 2'b00;
  logic          HWRITES = 1'b0;
  logic [2:0]    HSIZES = '0, HBURSTS = '0;
  logic [3:0]    HPROTS = '0;
  logic          HMASTLOCKS = 1'b0, HREADYS = 1'b1;
  logic          addr_accept = 1'b0, data_readyout = 1'b1, data_resp = 1'b0;
  logic          HREADYOUTS, HRESPS, sel_op, write_op, mastlock_op, trans_pending;
  logic [AW-1:0] addr_op;
  logic [1:0]    trans_op;
  logic [2:0]    size_op, burst_op;
  logic [3:0]    prot_op;

  nanosoc_busmatrix_input_hold #(.ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .sel_op(sel_op), .addr_op(addr_op),
    .trans_op(trans_op), .write_op(write_op), .size_op(size_op),
    .burst_op(burst_op), .prot_op(prot_op), .mastlock_op(mastlock_op),
    .trans_pending(trans_pending), .addr_accept(addr_accept),
    .data_readyout(data_readyout), .data_resp(data_resp)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic          sel;
    logic [1:0]    trans;
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    size;
    logic [2:0]    burst;
    logic [3:0]    prot;
    logic          lock;
    logic          accept;
    logic          dready;
    logic          dresp;
    logic          doReset;
    logic          hready;
  } stim_t;

  typedef struct packed {
    logic          ready;
    logic          resp;
    logic          sel;
    logic [AW-1:0] addr;
    logic [1:0]    trans;
    logic          write;
    logic [2:0]    size;
    logic [2:0]    burst;
    logic [3:0]    prot;
    logic          lock;
    logic          pending;
  } exp_t;

  stim_t heldQ[$];
  exp_t  expQ[$];
  logic  dataOpen = 1'b0;
  stim_t prevStim = '0;
  int    testsRun = 0;
  int    failCount = 0;

  function automatic logic isTransfer(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

  function automatic stim_t mkStim(input logic sel, input logic [1:0] trans,
                                   input logic [AW-1:0] addr, input logic write,
                                   input logic [2:0] size, input logic [2:0] burst,
                                   input logic lock, input logic accept,
                                   input logic dready, input logic dresp);
    stim_t s = '0;
    s.sel = sel; s.trans = trans; s.addr = addr; s.write = write;
    s.size = size; s.burst = burst; s.prot = 4'h3; s.lock = lock;
    s.accept = accept; s.dready = dready; s.dresp = dresp;
    return s;
  endfunction

  function automatic stim_t idleStim(input logic dready, input logic dresp);
    return mkStim(1'b1, HTRANS_IDLE, 32'hDEAD_0000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, dready, dresp);
  endfunction

  // A stalled request waits in heldQ; the master sees the held copy and a stall.
  function automatic exp_t modelOutputs(input stim_t s);
    exp_t e;
    stim_t h;
    if (heldQ.size() > 0) begin
      h = heldQ[0];
      e = '{ready: 1'b0, resp: 1'b0, sel: 1'b1, addr: h.addr, trans: h.trans,
            write: h.write, size: h.size, burst: h.burst, prot: h.prot,
            lock: h.lock, pending: 1'b1};
    end else begin
      e = '{ready: dataOpen ? s.dready : 1'b1, resp: dataOpen ? s.dresp : 1'b0,
            sel: s.sel, addr: s.addr, trans: s.sel ? s.trans : HTRANS_IDLE,
            write: s.write, size: s.size, burst: s.burst, prot: s.prot,
            lock: s.lock, pending: s.sel && isTransfer(s.trans)};
    end
    return e;
  endfunction

  task automatic modelClock(input stim_t s);
    logic masterIssues;
    masterIssues = s.sel && isTransfer(s.trans) && s.hready;
    if (heldQ.size() > 0 && s.accept) begin
      void'(heldQ.pop_front());
      dataOpen = 1'b1;
    end else if (masterIssues && s.accept) begin
      dataOpen = 1'b1;
    end else begin
      if (masterIssues) heldQ.push_back(s);
      if (s.dready) dataOpen = 1'b0;
    end
  endtask

  task automatic applyStimulus(input stim_t sIn);
    stim_t s;
    s = sIn;
    @(posedge HCLK);
    if (HRESETn) modelClock(prevStim);
    #1;
    if (s.doReset) begin
      HRESETn = 1'b0;
      heldQ.delete();
      dataOpen = 1'b0;
    end else begin
      HRESETn = 1'b1;
    end
    s.hready = (heldQ.size() > 0) ? 1'b0 : (dataOpen ? s.dready : 1'b1);
    HSELS = s.sel; HTRANSS = s.trans; HADDRS = s.addr; HWRITES = s.write;
    HSIZES = s.size; HBURSTS = s.burst; HPROTS = s.prot; HMASTLOCKS = s.lock;
    addr_accept = s.accept; data_readyout = s.dready; data_resp = s.dresp;
    HREADYS = s.hready;
    expQ.push_back(modelOutputs(s));
    prevStim = s;
  endtask

  task automatic cmp(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    testsRun++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("HREADYOUTS", AW'(HREADYOUTS), AW'(e.ready));
    cmp("HRESPS", AW'(HRESPS), AW'(e.resp));
    cmp("sel_op", AW'(sel_op), AW'(e.sel));
    cmp("addr_op", addr_op, e.addr);
    cmp("trans_op", AW'(trans_op), AW'(e.trans));
    cmp("write_op", AW'(write_op), AW'(e.write));
    cmp("size_op", AW'(size_op), AW'(e.size));
    cmp("burst_op", AW'(burst_op), AW'(e.burst));
    cmp("prot_op", AW'(prot_op), AW'(e.prot));
    cmp("mastlock_op", AW'(mastlock_op), AW'(e.lock));
    cmp("trans_pending", AW'(trans_pending), AW'(e.pending));
    if (HSELS && HTRANSS[1] && HREADYS) cmp("newTranWhilePend", AW'(HREADYOUTS), AW'(1'b1));
  endtask

  always @(negedge HCLK) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    stim_t s;
    s = idleStim(1'b1, 1'b0);
    s.sel = 1'b0;
    s.doReset = 1'b1;
    repeat (2) applyStimulus(s);

    // Pass-through write, then data phase waits 0,0,1.
    applyStimulus(mkStim(1, HTRANS_NONSEQ, 32'h2000_0010, 1, 3'd2, HBURST_SINGLE, 0, 1, 1, 0));
    applyStimulus(idleStim(0, 0));
    applyStimulus(idleStim(0, 0));
    applyStimulus(idleStim(1, 0));

    // Held read for three stalled cycles while the master wiggles its bus.
    applyStimulus(mkStim(1, HTRANS_NONSEQ, 32'h0000_1000, 0, 3'd2, HBURST_SINGLE, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      applyStimulus(mkStim(1, HTRANS_SEQ, 32'h5555_0000 + 32'(i * 4), 1, 3'd1, HBURST_INCR, 0, 0, 1, 0));
    applyStimulus(mkStim(1, HTRANS_SEQ, 32'h5555_0100, 1, 3'd1, HBURST_INCR, 0, 1, 1, 0));
    applyStimulus(idleStim(0, 0));
    applyStimulus(idleStim(1, 0));

    // INCR4 interrupted at the third beat.
    applyStimulus(mkStim(1, HTRANS_NONSEQ, 32'h100, 0, 3'd2, HBURST_INCR4, 0, 1, 1, 0));
    applyStimulus(mkStim(1, HTRANS_SEQ, 32'h104, 0, 3'd2, HBURST_INCR4, 0, 1, 1, 0));
    applyStimulus(mkStim(1, HTRANS_SEQ, 32'h108, 0, 3'd2, HBURST_INCR4, 0, 0, 1, 0));
    applyStimulus(mkStim(1, HTRANS_SEQ, 32'h10C, 0, 3'd2, HBURST_INCR4, 0, 0, 1, 0));
    applyStimulus(mkStim(1, HTRANS_SEQ, 32'h10C, 0, 3'd2, HBURST_INCR4, 0, 1, 1, 0));
    applyStimulus(idleStim(1, 0));

    // Two-cycle ERROR with the master going IDLE.
    applyStimulus(mkStim(1, HTRANS_NONSEQ, 32'h3000_0000, 1, 3'd2, HBURST_SINGLE, 0, 1, 1, 0));
    applyStimulus(idleStim(0, 1));
    applyStimulus(idleStim(1, 1));
    applyStimulus(idleStim(1, 0));

    // Locked transfer held for two cycles.
    applyStimulus(mkStim(1, HTRANS_NONSEQ, 32'h4000_0040, 1, 3'd2, HBURST_SINGLE, 1, 0, 1, 0));
    applyStimulus(mkStim(1, HTRANS_IDLE, 32'h0, 0, 3'd0, HBURST_SINGLE, 0, 0, 1, 0));
    applyStimulus(mkStim(1, HTRANS_IDLE, 32'h0, 0, 3'd0, HBURST_SINGLE, 0, 1, 1, 0));
    applyStimulus(idleStim(1, 0));

    // Reset while holding, then a clean pass-through.
    applyStimulus(mkStim(1, HTRANS_NONSEQ, 32'h5000_0000, 0, 3'd2, HBURST_SINGLE, 0, 0, 1, 0));
    applyStimulus(mkStim(1, HTRANS_NONSEQ, 32'h5000_0000, 0, 3'd2, HBURST_SINGLE, 0, 0, 0, 0));
    s = idleStim(1, 0);
    s.sel = 1'b0;
    s.doReset = 1'b1;
    applyStimulus(s);
    applyStimulus(mkStim(1, HTRANS_NONSEQ, 32'h6000_0008, 1, 3'd2, HBURST_SINGLE, 0, 1, 1, 0));
    applyStimulus(idleStim(1, 0));

    for (int i = 0; i < 400; i++) begin
      s = mkStim($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom() & 32'hFFFF_FFFC,
                 1'($urandom()), 3'($urandom_range(0, 2)), 3'($urandom()), 1'($urandom()),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0);
      s.prot = 4'($urandom());
      s.doReset = ($urandom_range(0, 60) == 0);
      applyStimulus(s);
    end

    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(posedge HCLK);
    if (expQ.size() > 0) begin
      failCount++;
      $display("[TB] FAIL scoreboardDrain: %0d entries left, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
